// File: rtl/simple_uart.sv
`timescale 1ns/1ps
// simple_uart: memory-mapped 8N1 console UART with a programmable baud divider.
// ser_rx is expected to arrive already synchronous to clk; the bit timing counts from the first low sample.
module simple_uart #(
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait
);

  localparam int unsigned DIV_W      = 32;
  localparam int unsigned BIT_CNT_W  = 4;
  localparam int unsigned DUMMY_BITS = 15;
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [1:0] {TX_DUMMY, TX_IDLE, TX_FRAME} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_t;

  logic [DIV_W-1:0]     r_div;
  logic [DIV_W-1:0]     w_period;
  logic [DIV_W-1:0]     w_half;
  logic                 w_div_wr;
  logic                 w_unused_di;

  tx_state_t            r_tx_state;
  tx_state_t            w_tx_next;
  logic [DIV_W-1:0]     r_tx_cnt;
  logic [BIT_CNT_W-1:0] r_tx_bits;
  logic [8:0]           r_tx_shift;
  logic                 r_ser_tx;
  logic                 r_dummy_owed;
  logic                 w_tx_tick;
  logic                 w_tx_load;
  logic                 w_tx_restart;

  rx_state_t            r_rx_state;
  rx_state_t            w_rx_next;
  logic [DIV_W-1:0]     r_rx_cnt;
  logic [BIT_CNT_W-1:0] r_rx_bits;
  logic [7:0]           r_rx_shift;
  logic [7:0]           r_rx_data;
  logic                 r_rx_valid;
  logic                 w_rx_tick;
  logic                 w_rx_mid;
  logic                 w_rx_store;

  // Divider register, byte-lane writable
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_div <= DIV_W'(DEFAULT_DIV);
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (reg_div_we[i]) r_div[8*i +: 8] <= reg_div_di[8*i +: 8];
      end
    end
  end

  assign w_period    = (r_div < DIV_W'(2)) ? DIV_W'(2) : r_div;
  assign w_half      = w_period >> 1;
  assign w_div_wr    = |reg_div_we;
  assign w_unused_di = ^reg_dat_di[31:8];

  assign reg_div_do   = r_div;
  assign ser_tx       = r_ser_tx;
  assign reg_dat_wait = reg_dat_we && (r_tx_state != TX_IDLE);
  assign reg_dat_do   = r_rx_valid ? {24'h0, r_rx_data} : 32'h0;

  // ---------------- transmitter ----------------
  assign w_tx_tick    = (r_tx_cnt >= w_period - DIV_W'(1));
  assign w_tx_load    = (r_tx_state == TX_IDLE) && reg_dat_we;
  assign w_tx_restart = (w_tx_next != r_tx_state) || (r_tx_state == TX_IDLE) ||
                        ((r_tx_state == TX_DUMMY) && w_div_wr);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) r_tx_state <= TX_DUMMY;
    else        r_tx_state <= w_tx_next;
  end

  // A divider write during a frame is remembered and replays the dummy once the frame ends
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_DUMMY: begin
        if (!w_div_wr && w_tx_tick && (r_tx_bits == BIT_CNT_W'(DUMMY_BITS - 1)))
          w_tx_next = TX_IDLE;
      end
      TX_IDLE: begin
        if (reg_dat_we)    w_tx_next = TX_FRAME;
        else if (w_div_wr) w_tx_next = TX_DUMMY;
      end
      TX_FRAME: begin
        if (w_tx_tick && (r_tx_bits == BIT_CNT_W'(FRAME_BITS - 1)))
          w_tx_next = (r_dummy_owed || w_div_wr) ? TX_DUMMY : TX_IDLE;
      end
      default: w_tx_next = TX_DUMMY;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_tx_cnt     <= '0;
      r_tx_bits    <= '0;
      r_tx_shift   <= '1;
      r_ser_tx     <= 1'b1;
      r_dummy_owed <= 1'b0;
    end else begin
      if (w_tx_restart) begin
        r_tx_cnt  <= '0;
        r_tx_bits <= '0;
      end else if (w_tx_tick) begin
        r_tx_cnt  <= '0;
        r_tx_bits <= r_tx_bits + BIT_CNT_W'(1);
      end else begin
        r_tx_cnt  <= r_tx_cnt + DIV_W'(1);
      end

      if (w_tx_next != TX_FRAME) r_dummy_owed <= 1'b0;
      else if (w_div_wr)         r_dummy_owed <= 1'b1;

      if (w_tx_load) begin
        r_ser_tx   <= 1'b0;
        r_tx_shift <= {1'b1, reg_dat_di[7:0]};
      end else if ((r_tx_state == TX_FRAME) && w_tx_tick) begin
        if (r_tx_bits == BIT_CNT_W'(FRAME_BITS - 1)) begin
          r_ser_tx <= 1'b1;
        end else begin
          r_ser_tx   <= r_tx_shift[0];
          r_tx_shift <= {1'b1, r_tx_shift[8:1]};
        end
      end
    end
  end

  // ---------------- receiver ----------------
  assign w_rx_tick  = (r_rx_cnt >= w_period - DIV_W'(1));
  assign w_rx_mid   = (r_rx_cnt >= w_half - DIV_W'(1));
  assign w_rx_store = (r_rx_state == RX_DATA) && w_rx_tick &&
                      (r_rx_bits == BIT_CNT_W'(DATA_BITS)) && ser_rx;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (!ser_rx) w_rx_next = RX_START;
      RX_START: if (w_rx_mid) w_rx_next = ser_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && (r_rx_bits == BIT_CNT_W'(DATA_BITS))) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // Sample counter restarts at the mid-start point so data samples land mid-bit
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_rx_cnt   <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if ((w_rx_next != r_rx_state) || (r_rx_state == RX_IDLE)) begin
        r_rx_cnt  <= '0;
        r_rx_bits <= '0;
      end else if ((r_rx_state == RX_DATA) && w_rx_tick) begin
        r_rx_cnt   <= '0;
        r_rx_bits  <= r_rx_bits + BIT_CNT_W'(1);
        r_rx_shift <= {ser_rx, r_rx_shift[7:1]};
      end else begin
        r_rx_cnt   <= r_rx_cnt + DIV_W'(1);
      end

      if (w_rx_store) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (reg_dat_re) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simple_uart.sv
`timescale 1ns/1ps
// tb_simple_uart: directed stimulus with a cycle-level behavioural model checked every clock,
// plus hand-computed literal expectations for the key scenarios.
module tb_simple_uart;

  localparam int unsigned DEF_DIV = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ser_tx;
  logic        ser_rx;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic [31:0] reg_div_do;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  simple_uart #(.DEFAULT_DIV(DEF_DIV)) dut (
    .clk(clk), .resetn(resetn), .ser_tx(ser_tx), .ser_rx(ser_rx),
    .reg_div_we(reg_div_we), .reg_div_di(reg_div_di), .reg_div_do(reg_div_do),
    .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
    .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int per(input logic [31:0] d);
    return (d < 32'd2) ? 2 : int'(d);
  endfunction

  // Model state: line timing expressed as cycle numbers
  typedef struct { int t; logic [7:0] b; } rx_ev_t;
  rx_ev_t      rxq[$];
  logic [31:0] m_div;
  int          m_busy_until;
  logic        m_fvalid;
  logic [9:0]  m_frame;
  int          m_fstart;
  int          m_fp;
  logic        m_rx_valid;
  logic [7:0]  m_rx_byte;
  logic        m_re_prev;

  always @(negedge clk) begin : model_cmp
    logic        exp_tx;
    logic        exp_wait;
    logic [31:0] exp_do;
    logic [31:0] nd;
    if (resetn) begin
      m_div        = 32'(DEF_DIV);
      m_busy_until = cyc + 1 + 15 * per(32'(DEF_DIV));
      m_fvalid     = 1'b0;
      m_rx_valid   = 1'b0;
      m_re_prev    = 1'b0;
      rxq.delete();
    end else begin
      if (m_re_prev) m_rx_valid = 1'b0;
      while (rxq.size() > 0 && rxq[0].t <= cyc) begin
        if (rxq[0].t == cyc) begin
          m_rx_valid = 1'b1;
          m_rx_byte  = rxq[0].b;
        end
        void'(rxq.pop_front());
      end
    end

    exp_tx = 1'b1;
    if (m_fvalid && cyc >= m_fstart && cyc < m_fstart + 10 * m_fp)
      exp_tx = m_frame[(cyc - m_fstart) / m_fp];
    exp_wait = reg_dat_we && (cyc < m_busy_until);
    exp_do   = m_rx_valid ? {24'h0, m_rx_byte} : 32'h0;

    check("m_ser_tx",   {31'h0, ser_tx},       {31'h0, exp_tx});
    check("m_dat_wait", {31'h0, reg_dat_wait}, {31'h0, exp_wait});
    check("m_dat_do",   reg_dat_do,            exp_do);
    check("m_div_do",   reg_div_do,            m_div);

    if (!resetn) begin
      m_re_prev = reg_dat_re;
      if (|reg_div_we) begin
        nd = m_div;
        for (int i = 0; i < 4; i++)
          if (reg_div_we[i]) nd[8*i +: 8] = reg_div_di[8*i +: 8];
        m_div        = nd;
        m_busy_until = cyc + 1 + 15 * per(nd);
      end else if (reg_dat_we && cyc >= m_busy_until) begin
        m_fvalid     = 1'b1;
        m_fstart     = cyc + 1;
        m_fp         = per(m_div);
        m_frame      = {1'b1, reg_dat_di[7:0], 1'b0};
        m_busy_until = m_fstart + 10 * m_fp;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame on ser_rx; a good stop bit schedules the byte at the stop-sample cycle
  task automatic send_rx(input logic [7:0] b, input logic stop, input int p);
    logic [9:0] f;
    rx_ev_t     ev;
    f = {stop, b, 1'b0};
    if (stop) begin
      ev.t = cyc + 1 + p / 2 + 9 * p;
      ev.b = b;
      rxq.push_back(ev);
    end
    for (int i = 0; i < 10; i++) begin
      ser_rx = f[i];
      repeat (p) tick();
    end
    ser_rx = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int         n;
    logic [9:0] got;
    resetn     = 1'b1;
    ser_rx     = 1'b1;
    reg_div_we = '0;
    reg_div_di = '0;
    reg_dat_we = 1'b0;
    reg_dat_re = 1'b0;
    reg_dat_di = '0;
    repeat (3) tick();
    check("rst_div",    reg_div_do, 32'd1);
    check("rst_ser_tx", {31'h0, ser_tx}, 32'd1);
    check("rst_dat_do", reg_dat_do, 32'h0);
    resetn = 1'b0;
    #1;
    check("rst_wait_idle", {31'h0, reg_dat_wait}, 32'd0);

    // Byte-lane divider writes
    reg_div_we = 4'b0011; reg_div_di = 32'h0000_0004; tick();
    reg_div_we = 4'b0000; #1;
    check("div_lo", reg_div_do, 32'h0000_0004);
    reg_div_we = 4'b0100; reg_div_di = 32'h00AB_0000; tick();
    reg_div_we = 4'b0000; #1;
    check("div_lane2", reg_div_do, 32'h00AB_0004);
    reg_div_we = 4'b1111; reg_div_di = 32'h0000_0004; tick();
    reg_div_we = 4'b0000;

    // TX 0xA5 held write: 60-cycle dummy, then a 40-cycle frame stalling the next write
    reg_dat_we = 1'b1; reg_dat_di = 32'hA5;
    n = 0;
    while (n < 200) begin
      #1;
      if (!reg_dat_wait) break;
      n++;
      tick();
    end
    check("tx_dummy_len", 32'(n), 32'd60);
    tick();
    reg_dat_di = 32'h5A;
    n = 0;
    got = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (i % 4 == 1) got[i / 4] = ser_tx;
      if (reg_dat_wait) n++;
      tick();
    end
    #1;
    check("tx_bits_a5",   {22'h0, got}, 32'h0000_034A);
    check("tx_stall_len", 32'(n), 32'd40);
    check("tx_wait_drop", {31'h0, reg_dat_wait}, 32'd0);
    tick();
    reg_dat_we = 1'b0;
    repeat (45) tick();

    // RX good byte, then acknowledge
    send_rx(8'h3C, 1'b1, 4);
    #1;
    check("rx_3c", reg_dat_do, 32'h0000_003C);
    reg_dat_re = 1'b1; tick();
    reg_dat_re = 1'b0; #1;
    check("rx_ack", reg_dat_do, 32'h0);

    // Framing error and a one-cycle glitch deliver nothing
    send_rx(8'h3C, 1'b0, 4);
    repeat (8) tick();
    check("rx_frame_err", reg_dat_do, 32'h0);
    ser_rx = 1'b0; tick();
    ser_rx = 1'b1;
    repeat (12) tick();
    check("rx_glitch", reg_dat_do, 32'h0);

    // Overrun: second byte replaces the first
    send_rx(8'h11, 1'b1, 4);
    send_rx(8'h55, 1'b1, 4);
    #1;
    check("rx_overrun", reg_dat_do, 32'h0000_0055);
    reg_dat_re = 1'b1; tick();
    reg_dat_re = 1'b0;

    // Full duplex: transmit 0x0F while receiving 0x96
    reg_dat_we = 1'b1; reg_dat_di = 32'h0F; tick();
    reg_dat_we = 1'b0;
    send_rx(8'h96, 1'b1, 4);
    #1;
    check("rx_duplex", reg_dat_do, 32'h0000_0096);
    repeat (10) tick();

    // Async reset in the middle of a frame, then dummy replay at the default divider
    reg_dat_we = 1'b1; reg_dat_di = 32'h00; tick();
    reg_dat_we = 1'b0;
    repeat (6) tick();
    #1;
    check("tx_pre_rst", {31'h0, ser_tx}, 32'd0);
    #1;
    resetn = 1'b1;
    #1;
    check("rst_async_tx",  {31'h0, ser_tx}, 32'd1);
    check("rst_async_div", reg_div_do, 32'd1);
    tick(); tick();
    resetn = 1'b0;
    reg_dat_we = 1'b1; reg_dat_di = 32'hC3;
    n = 0;
    while (n < 200) begin
      #1;
      if (!reg_dat_wait) break;
      n++;
      tick();
    end
    check("tx_dummy_replay", 32'(n), 32'd30);
    tick();
    reg_dat_we = 1'b0;
    repeat (25) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
